// File: rtl/cop0_exc_unit_pkg.sv
// ---------------------------------------------------------------------------
// cop0_exc_unit_pkg
// Shared definitions for the coprocessor-0 / exception responder:
//   - CP0 register indexes used by MTC0/MFC0 (Status, Cause, EPC)
//   - Status bit positions (IE, EXL, UM)
//   - ExcCode constants written into Cause[6:2]
//   - sequencing states of the exception/ERET responder
// Optional feature macro: COP0_IRQ_EN (interrupt input and Status.IE).
// ---------------------------------------------------------------------------
package cop0_exc_unit_pkg;

  localparam logic [4:0] CP0_STATUS_IDX = 5'd12;
  localparam logic [4:0] CP0_CAUSE_IDX  = 5'd13;
  localparam logic [4:0] CP0_EPC_IDX    = 5'd14;

  localparam int STATUS_IE_BIT  = 0;
  localparam int STATUS_EXL_BIT = 1;
  localparam int STATUS_UM_BIT  = 4;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/cop0_regfile.sv
// ---------------------------------------------------------------------------
// cop0_regfile
// Storage for Status, Cause and EPC with write masking and the MFC0 read mux.
// Only Status.EXL/UM (and IE when COP0_IRQ_EN is defined), Cause.ExcCode and
// the full EPC are stored; every other bit reads as zero.
// Update priority inside one cycle: exception entry, then ERET, then MTC0.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   wr_en_i/idx/data   MTC0 write (already qualified by the top level)
//   exc_take_i         exception entry: load EPC/ExcCode, set EXL
//   exc_code_i/pc_i    ExcCode and faulting PC for the entry
//   eret_i             ERET: clear EXL
//   rd_idx_i/rd_data_o combinational MFC0 read
//   exl_o, um_o, epc_o current state for the top level
//   ie_o               Status.IE (only with COP0_IRQ_EN)
// ---------------------------------------------------------------------------
module cop0_regfile
  import cop0_exc_unit_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_idx_i,
  input  logic [31:0] wr_data_i,
  input  logic        exc_take_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        eret_i,
  input  logic [4:0]  rd_idx_i,
  output logic [31:0] rd_data_o,
  output logic        exl_o,
  output logic        um_o,
`ifdef COP0_IRQ_EN
  output logic        ie_o,
`endif
  output logic [31:0] epc_o
);

  logic        exl_q;
  logic        um_q;
  logic        ie;
  logic [4:0]  code_q;
  logic [31:0] epc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exl_q  <= 1'b0;
      um_q   <= 1'b0;
      code_q <= EXC_INT;
      epc_q  <= '0;
    end else if (exc_take_i) begin
      // No nesting: a second exception simply overwrites EPC and ExcCode.
      exl_q  <= 1'b1;
      code_q <= exc_code_i;
      epc_q  <= exc_pc_i;
    end else if (eret_i) begin
      exl_q <= 1'b0;
    end else if (wr_en_i) begin
      case (wr_idx_i)
        CP0_STATUS_IDX: begin
          exl_q <= wr_data_i[STATUS_EXL_BIT];
          um_q  <= wr_data_i[STATUS_UM_BIT];
        end
        CP0_CAUSE_IDX: code_q <= wr_data_i[6:2];
        CP0_EPC_IDX:   epc_q  <= wr_data_i;
        default: ;
      endcase
    end
  end

`ifdef COP0_IRQ_EN
  logic ie_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ie_q <= 1'b0;
    end else if (!exc_take_i && !eret_i && wr_en_i && wr_idx_i == CP0_STATUS_IDX) begin
      ie_q <= wr_data_i[STATUS_IE_BIT];
    end
  end

  assign ie   = ie_q;
  assign ie_o = ie_q;
`else
  assign ie = 1'b0;
`endif

  always_comb begin
    rd_data_o = '0;
    case (rd_idx_i)
      CP0_STATUS_IDX: begin
        rd_data_o[STATUS_IE_BIT]  = ie;
        rd_data_o[STATUS_EXL_BIT] = exl_q;
        rd_data_o[STATUS_UM_BIT]  = um_q;
      end
      CP0_CAUSE_IDX: rd_data_o[6:2] = code_q;
      CP0_EPC_IDX:   rd_data_o      = epc_q;
      default:       rd_data_o      = '0;
    endcase
  end

  assign exl_o = exl_q;
  assign um_o  = um_q;
  assign epc_o = epc_q;

endmodule

// File: rtl/cop0_exc_unit.sv
// ---------------------------------------------------------------------------
// cop0_exc_unit
// Coprocessor-0 and exception responder. Resolves commit-time requests by
// priority (irq, RI, Ov, Sys, ERET, MTC0), updates CP0 state through
// cop0_regfile, and sequences a one-cycle flush/redirect followed by a
// DRAIN_CYCLES fetch stall.
// Optional feature macro: COP0_IRQ_EN adds input irq and Status.IE.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   commit_valid/pc      committing instruction qualifier and its PC
//   exc_ri/sys/ov/ret    exception and ERET requests
//   cowrite/co_widx/co_wdata  MTC0 write
//   co_ridx/co_rdata     combinational MFC0 read
//   cpu_mode             1 = kernel (EXL | ~UM)
//   flush, pc_sel, pc_target  one-cycle pipeline kill and fetch redirect
//   stall_fetch          fetch hold during drain
// ---------------------------------------------------------------------------
module cop0_exc_unit
  import cop0_exc_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        exc_ri,
  input  logic        exc_sys,
  input  logic        exc_ov,
  input  logic        exc_ret,
  input  logic        cowrite,
  input  logic [4:0]  co_widx,
  input  logic [31:0] co_wdata,
  input  logic [4:0]  co_ridx,
`ifdef COP0_IRQ_EN
  input  logic        irq,
`endif
  output logic [31:0] co_rdata,
  output logic        cpu_mode,
  output logic        flush,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        stall_fetch
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;

  logic        take_exc;
  logic [4:0]  exc_code;
  logic        take_ret;
  logic        take_wr;
  logic        exl;
  logic        um;
  logic [31:0] epc;

`ifdef COP0_IRQ_EN
  logic ie;
`endif

  cop0_regfile u_regfile (
    .clk_i      (clk),
    .rst_ni     (reset),
    .wr_en_i    (take_wr),
    .wr_idx_i   (co_widx),
    .wr_data_i  (co_wdata),
    .exc_take_i (take_exc),
    .exc_code_i (exc_code),
    .exc_pc_i   (commit_pc),
    .eret_i     (take_ret),
    .rd_idx_i   (co_ridx),
    .rd_data_o  (co_rdata),
    .exl_o      (exl),
    .um_o       (um),
`ifdef COP0_IRQ_EN
    .ie_o       (ie),
`endif
    .epc_o      (epc)
  );

  assign cpu_mode = exl | ~um;

  // Requests are only honoured from IDLE; in FLUSH/DRAIN they belong to
  // instructions that are being killed. ERET in user mode never executes
  // (the decoder pairs it with exc_ri), and it still masks a lower MTC0.
  always_comb begin
    take_exc = 1'b0;
    exc_code = EXC_INT;
    take_ret = 1'b0;
    take_wr  = 1'b0;
    if (state_q == ST_IDLE && commit_valid) begin
`ifdef COP0_IRQ_EN
      if (irq && ie && !exl) begin
        take_exc = 1'b1;
        exc_code = EXC_INT;
      end else
`endif
      if (exc_ri) begin
        take_exc = 1'b1;
        exc_code = EXC_RI;
      end else if (exc_ov) begin
        take_exc = 1'b1;
        exc_code = EXC_OV;
      end else if (exc_sys) begin
        take_exc = 1'b1;
        exc_code = EXC_SYS;
      end else if (exc_ret) begin
        take_ret = cpu_mode;
      end else if (cowrite) begin
        take_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // The ERET target is captured from the EPC register before the edge, so a
  // same-cycle CP0 update can never leak into the redirect address.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (take_exc) begin
          state_d  = ST_FLUSH;
          target_d = HANDLER_ADDR;
        end else if (take_ret) begin
          state_d  = ST_FLUSH;
          target_d = epc;
        end
      end
      ST_FLUSH: begin
        state_d = ST_DRAIN;
        cnt_d   = 4'(DRAIN_CYCLES - 1);
      end
      ST_DRAIN: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flush       = (state_q == ST_FLUSH);
  assign pc_sel      = (state_q == ST_FLUSH);
  assign pc_target   = (state_q == ST_FLUSH) ? target_q : 32'h0;
  assign stall_fetch = (state_q == ST_DRAIN);

endmodule

// File: doc/cop0_exc_unit.md
Name: cop0_exc_unit

Overview:
- Coprocessor-0 and exception responder for the MIPS pipeline; consumes the decoder's exc_ri, exc_sys, exc_ret and cowrite requests at commit and produces cpu_mode back to the decoder.
- Holds Status, Cause and EPC, and sequences exception entry and ERET return.
- On each event it flushes the pipeline, redirects fetch, and stalls fetch for a fixed drain period.

Parameters:
- HANDLER_ADDR, 32'h8000_0180, exception vector driven on pc_target at entry.
- DRAIN_CYCLES, 3, cycles stall_fetch is held after the flush cycle (legal range 1-15).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- commit_valid  in  1  an instruction is committing this cycle; qualifies every request below
- commit_pc  in  32  PC of the committing instruction
- exc_ri  in  1  reserved/privileged instruction
- exc_sys  in  1  syscall
- exc_ov  in  1  arithmetic overflow from ALU
- exc_ret  in  1  ERET
- cowrite  in  1  MTC0 commit
- co_widx  in  5  MTC0 destination register
- co_wdata  in  32  MTC0 data
- co_ridx  in  5  MFC0 source register
- co_rdata  out  32  combinational read: 12 gives Status, 13 gives Cause, 14 gives EPC, any other index gives 0
- cpu_mode  out  1  1 = kernel; equals Status.EXL OR NOT Status.UM
- flush  out  1  kill all in-flight instructions
- pc_sel  out  1  fetch takes pc_target this cycle
- pc_target  out  32  redirect address
- stall_fetch  out  1  hold fetch during drain

Behaviour:
- Reset: Status=0, Cause=0, EPC=0, state IDLE, flush=0, pc_sel=0, pc_target=0, stall_fetch=0. Because UM=0, cpu_mode=1 out of reset.
- Status bit 1 is EXL and bit 4 is UM; all other Status bits read 0. Cause[6:2] is ExcCode; all other Cause bits read 0.
- ExcCode values: Int=0, Sys=8, RI=10, Ov=12.
- Events are sampled only when commit_valid=1 and state=IDLE. Priority, highest first: exc_ri, exc_ov, exc_sys, exc_ret, cowrite.
- Exception entry (RI/Ov/Sys) in IDLE; next edge:
  - EPC <= commit_pc; Cause.ExcCode <= code; EXL <= 1.
  - flush=1, pc_sel=1, pc_target=HANDLER_ADDR for exactly one cycle (state FLUSH).
- ERET in IDLE:
  - If cpu_mode=1: EXL <= 0; FLUSH cycle with pc_target=EPC, using the EPC value before any same-cycle update.
  - If cpu_mode=0: the decoder has already raised exc_ri, which takes priority, so ERET is never performed in user mode.
- Exception while EXL=1: EPC and ExcCode are still overwritten (no nesting support); EXL stays 1.
- State machine:
  - IDLE goes to FLUSH on any exception or ERET.
  - FLUSH always goes to DRAIN, loading a 4-bit counter with DRAIN_CYCLES-1.
  - DRAIN holds stall_fetch=1 and decrements the counter; it returns to IDLE on the cycle after the counter reaches 0.
  - Total fetch blackout is 1 + DRAIN_CYCLES cycles.
- In FLUSH and DRAIN, all exc_* and cowrite inputs are ignored because they come from flushed instructions.
- MTC0 (cowrite in IDLE with no higher-priority event): writes Status (only EXL and UM stored), Cause (only ExcCode stored), or EPC (full 32 bits). Writes to other indexes are dropped. Effect is visible on co_rdata and cpu_mode from the next cycle.
- cowrite together with any exception in the same cycle: the exception wins and the write is dropped.
- Reset asserted mid-FLUSH or mid-DRAIN: everything returns asynchronously to reset values, and no redirect is issued after release.

Optional Feature:
- Macro COP0_IRQ_EN.
- When defined:
  - Adds input irq (1 bit) and Status bit 0 IE (writable via MTC0).
  - irq is sampled in IDLE when IE=1, EXL=0 and commit_valid=1.
  - Priority is above exc_ri.
  - Entry uses ExcCode=0 and EPC=commit_pc.
- When undefined: no irq port, IE reads 0, and interrupts are never taken.

Decomposition:
- Shared package/defines header holds:
  - CP0 register indexes (12/13/14);
  - Status bit positions (IE=0, EXL=1, UM=4);
  - ExcCode constants;
  - state encodings IDLE/FLUSH/DRAIN.
- Sub-module cop0_regfile holds Status/Cause/EPC storage, write masking and the MFC0 read mux. The top level owns priority logic, the FSM and the drain counter.

Test Plan:
- Release reset; read co_ridx=12 -> co_rdata=0, cpu_mode=1; flush, pc_sel and stall_fetch all 0.
- MTC0 co_widx=12 co_wdata=32'h0000_0010, then exc_sys with commit_pc=32'h0040_0020:
  - after the write, cpu_mode=0;
  - at the syscall, flush=pc_sel=1 for 1 cycle with pc_target=32'h8000_0180;
  - EPC reads 32'h0040_0020, Cause reads 32'h20, cpu_mode=1;
  - stall_fetch=1 for exactly 3 cycles.
- exc_ri and exc_ov together -> Cause=32'h28 (RI wins). An exc_sys asserted during DRAIN is ignored: EPC and Cause are unchanged.
- From the previous state, ERET with EPC=32'h0040_0024 -> pc_target=32'h0040_0024, EXL=0, Status reads 32'h10, cpu_mode=0.
- cowrite to EPC with exc_ov in the same cycle -> EPC=commit_pc (write dropped), Cause=32'h30.
- Assert reset during DRAIN cycle 2 -> stall_fetch drops immediately; after release, all registers are 0 and no pc_sel pulse occurs.
